// File: rtl/hazard_input_cond.sv
// hazard_input_cond
//   Conditioning stage in front of the hazard-light pattern FSM. Each raw
//   wind-direction switch is passed through a two-flop synchroniser and a
//   stability-count debouncer. The clean pair is encoded into a 2-bit mode,
//   and a two-state handshake reports each mode change to the slower consumer.
//
//   Ports:
//     clk          board clock, rising edge
//     reset        asynchronous, active-high, clears every flop
//     sw1, sw0     raw slide switches (right-to-left / left-to-right request)
//     sw1_clean    debounced sw1
//     sw0_clean    debounced sw0
//     mode         registered mode: 00 calm, 01 sw0 dir, 10 sw1 dir
//     mode_pending high from a mode change until the consumer acknowledges it
//     mode_ack     consumer acknowledge (level, one or more cycles)
//     overrun      sticky: a mode change arrived while mode_pending was high
//
//   Optional build macro HAZARD_HOLD_ILLEGAL_EN: when it is defined, a clean
//   pattern of 11 holds the last legal mode. When it is undefined, 11 encodes
//   as calm.

// One switch: synchroniser plus debouncer.
module hazard_db #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1, s;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            // Any return to the accepted level restarts the stability window.
            if (s == clean) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                clean <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module hazard_input_cond #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw1,
    input  logic       sw0,
    output logic       sw1_clean,
    output logic       sw0_clean,
    output logic [1:0] mode,
    output logic       mode_pending,
    input  logic       mode_ack,
    output logic       overrun
);
    localparam int NUM_SW = 2;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} hs_state_t;

    logic [NUM_SW-1:0] raw, clean;
    logic [1:0]        next_mode;
    logic              mode_chg;
    hs_state_t         state, state_nxt;

    assign raw = {sw1, sw0};

    // One debouncer per switch. The two debouncers are independent.
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        hazard_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .clean (clean[i])
        );
    end

    assign sw1_clean = clean[1];
    assign sw0_clean = clean[0];

    always_comb begin
        next_mode = 2'b00;
        case (clean)
            2'b01:   next_mode = 2'b01;
            2'b10:   next_mode = 2'b10;
`ifdef HAZARD_HOLD_ILLEGAL_EN
            2'b11:   next_mode = mode;  // both set: keep the last legal mode
`else
            2'b11:   next_mode = 2'b00; // both set: treat as calm
`endif
            default: next_mode = 2'b00;
        endcase
    end

    assign mode_chg = (next_mode != mode);

    // When both clean bits move on the same edge, the mode is updated once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mode <= 2'b00;
        else       mode <= next_mode;
    end

    // Handshake FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Handshake FSM: next state. A fresh change takes priority over an ack.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mode_chg) state_nxt = PEND;
            PEND: if (!mode_chg && mode_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake FSM: outputs.
    always_comb begin
        mode_pending = (state == PEND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          overrun <= 1'b0;
        else if (state == PEND && mode_chg) overrun <= 1'b1;
    end
endmodule

// File: doc/hazard_input_cond.md
Name: hazard_input_cond

Overview:
- Upstream conditioning stage for the hazard-light pattern FSM.
- Synchronises and debounces the two wind-direction slide switches, then encodes them into a 2-bit mode.
- Holds a pending-change flag that the slower pattern FSM acknowledges.
- Runs on the 50 MHz board clock, so the consumer never sees raw or metastable switch levels.

Parameters:
- DB_CYCLES, 1000000, consecutive stable cycles required before a switch level is accepted (20 ms at 50 MHz; benches override to 4).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears every flop immediately.
- sw1  in  1  raw switch, wind blowing right-to-left request.
- sw0  in  1  raw switch, wind blowing left-to-right request.
- sw1_clean  out  1  debounced sw1.
- sw0_clean  out  1  debounced sw0.
- mode  out  2  registered mode: 00 calm, 01 sw0 direction, 10 sw1 direction.
- mode_pending  out  1  high from a mode change until acknowledged.
- mode_ack  in  1  consumer acknowledge, one or more cycles wide.
- overrun  out  1  sticky: a mode change occurred while mode_pending was already high.

Behaviour:
- Reset values: all sync flops 0, counters 0, sw1_clean=0, sw0_clean=0, mode=00, mode_pending=0, overrun=0.
- Synchroniser: per switch, two-flop chain; s = second flop.
- Debounce, per switch, independent:
  - if s == clean: count <= 0.
  - else if count == DB_CYCLES-1: clean <= s, count <= 0.
  - else: count <= count+1.
- Debounce latency: raw edge first captured at edge E; clean changes at edge E+DB_CYCLES+1.
- Any return of s to clean before acceptance restarts the count from 0; glitches shorter than DB_CYCLES produce no output change.
- Mode encode (combinational next_mode from clean bits): {sw1_clean,sw0_clean} 00->00, 01->01, 10->10, 11->00 (illegal treated as calm; see Optional Feature).
- mode register: mode <= next_mode every cycle, i.e. one cycle after the clean bits change.
- Handshake FSM, two states, IDLE (mode_pending=0) and PEND (mode_pending=1):
  - IDLE -> PEND when next_mode != mode.
  - PEND -> IDLE on mode_ack=1 with next_mode == mode.
  - PEND stays PEND on mode_ack=1 with next_mode != mode; the new change wins over the ack.
  - In PEND, next_mode != mode sets overrun <= 1; overrun is cleared only by reset.
  - mode_ack in IDLE is ignored.
- Both switches settling on the same edge yields a single mode update and a single pending event.
- Reset asserted mid-debounce or mid-PEND returns everything to reset values immediately; no pending event is generated on reset release if switches read 00.

Optional Feature:
- Macro: HAZARD_HOLD_ILLEGAL_EN.
- Defined: clean 11 leaves next_mode = current mode (last legal mode held); no pending event is raised on entering or leaving 11 unless the resulting legal mode differs.
- Undefined: 11 encodes as calm 00, exactly as in Behaviour.

Test Plan (DB_CYCLES=4):
- Reset with sw1=sw0=0 -> all outputs 0; after release, hold 10 cycles -> outputs remain 0, mode_pending=0.
- sw1 0->1 captured at edge E -> sw1_clean=1 at E+5, mode=10 and mode_pending=1 at E+6; mode_ack pulse -> mode_pending=0 next edge, overrun=0.
- sw0 pulse high 3 cycles then low -> sw0_clean never rises, mode stays 00, mode_pending stays 0.
- sw0=1 settle (mode 01, pending), no ack, then sw0=0 settle -> mode=00, mode_pending=1, overrun=1 and stays 1 after ack.
- mode_ack asserted on the same edge a new change registers -> mode_pending remains 1; second ack clears it.
- Both switches 1 after mode=10: macro undefined -> mode=00 with pending; macro defined -> mode stays 10, no pending. Reset mid-count -> clean bits 0, count restarts.
